pic_host_if: RTL and testbench

- CPU-side master for the interrupt controller bus.
- Watches the controller's interrupt request output and runs the two-pulse interrupt-acknowledge sequence. Captures the 8-bit vector on the second pulse and hands it to the CPU core through a valid/ack handshake.
- On a core request, performs the end-of-interrupt command write (OCW2 non-specific EOI, 8'h20, a0=0) with chip select and write strobe held long enough for the controller's clocked capture.

---
 rtl/pic_host_if_pkg.sv | 28 ++
 rtl/pic_host_if_sync2.sv | 26 ++
 rtl/pic_host_if.sv | 162 ++++++++++++++++
 tb/tb_pic_host_if.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pic_host_if_pkg.sv
// Shared encodings for the interrupt-controller host interface: one-hot FSM states
// and the controller's OCW2/OCW3 command field constants.
package pic_host_if_pkg;

    typedef enum logic [6:0] {
        S_IDLE    = 7'b000_0001,
        S_ACK1    = 7'b000_0010,
        S_GAP     = 7'b000_0100,
        S_ACK2    = 7'b000_1000,
        S_DELIVER = 7'b001_0000,
        S_EOI_WR  = 7'b010_0000,
        S_EOI_REC = 7'b100_0000
    } state_e;

    // Bits [4:3] of a command byte select the OCW type.
    localparam logic [1:0] OCW2_SEL    = 2'b00;
    localparam logic [1:0] OCW3_SEL    = 2'b01;
    localparam logic [1:0] OCW3_RD_IRR = 2'b10;
    localparam logic [1:0] OCW3_RD_ISR = 2'b11;
    localparam logic [2:0] OCW2_NS_EOI = 3'b001;

    localparam logic [7:0] EOI_CMD_DEF = {OCW2_NS_EOI, OCW2_SEL, 3'b000};

    function automatic logic [7:0] ocw3_read(input logic sel_isr);
        return {3'b000, OCW3_SEL, 1'b0, sel_isr ? OCW3_RD_ISR : OCW3_RD_IRR};
    endfunction

endpackage

// File: rtl/pic_host_if_sync2.sv
// Two-flop synchronizer for asynchronous level inputs; 2-cycle latency, no backpressure.
module pic_host_if_sync2 #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] meta_q;
    logic [W-1:0] sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/pic_host_if.sv
// CPU-side bus master for the interrupt controller: two-pulse INTA vector fetch and EOI write.
// intr->vec_valid latency 3+2*PULSE_CYC+GAP_CYC; vector held in DELIVER until vec_ack.
module pic_host_if
    import pic_host_if_pkg::*;
#(
    parameter int unsigned PULSE_CYC = 4,
    parameter int unsigned GAP_CYC   = 2,
    parameter logic [7:0]  EOI_CMD   = EOI_CMD_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       intr,
    input  logic       int_en,
    output logic       vec_valid,
    output logic [7:0] vector,
    input  logic       vec_ack,
    input  logic       eoi_req,
    output logic       eoi_done,
    output logic       inta_n,
    output logic       cs_n,
    output logic       wr_n,
    output logic       rd_n,
    output logic       a0,
    output logic [7:0] d_out,
    output logic       d_oe,
    input  logic [7:0] d_in
);

    localparam logic [3:0] PULSE_LD = 4'(PULSE_CYC - 1);
    localparam logic [3:0] GAP_LD   = 4'(GAP_CYC - 1);

    state_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       hold_q, hold_d;
    logic       intr_s;

    logic       inta_n_q;
    logic       strobe_n_q;
    logic       d_oe_q;
    logic [7:0] d_out_q;
    logic       vec_valid_q;
    logic [7:0] vector_q;
    logic       eoi_done_q;

    pic_host_if_sync2 #(.W(1)) u_intr_sync (
        .clk (clk),
        .rst (rst),
        .d_i (intr),
        .q_o (intr_s)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hold_d  = hold_q;
        unique case (state_q)
            S_IDLE: begin
                if (eoi_req) begin
                    state_d = S_EOI_WR;
                    cnt_d   = PULSE_LD;
                    hold_d  = 1'b0;
                end else if (intr_s && int_en) begin
                    state_d = S_ACK1;
                    cnt_d   = PULSE_LD;
                end
            end
            S_ACK1: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_GAP;
                    cnt_d   = GAP_LD;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_GAP: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_ACK2;
                    cnt_d   = PULSE_LD;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_ACK2: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_DELIVER;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_DELIVER: begin
                if (vec_ack) begin
                    state_d = S_IDLE;
                end
            end
            S_EOI_WR: begin
                // One extra cycle with strobes released but data still driven.
                if (hold_q) begin
                    state_d = S_EOI_REC;
                    cnt_d   = GAP_LD;
                    hold_d  = 1'b0;
                end else if (cnt_q == 4'd0) begin
                    hold_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_EOI_REC: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 4'd0;
                hold_d  = 1'b0;
            end
        endcase
    end

    // Outputs are registered from the next state so they align with state_q.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= 4'd0;
            hold_q      <= 1'b0;
            inta_n_q    <= 1'b1;
            strobe_n_q  <= 1'b1;
            d_oe_q      <= 1'b0;
            d_out_q     <= 8'h00;
            vec_valid_q <= 1'b0;
            vector_q    <= 8'h00;
            eoi_done_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            hold_q      <= hold_d;
            inta_n_q    <= !((state_d == S_ACK1) || (state_d == S_ACK2));
            strobe_n_q  <= !((state_d == S_EOI_WR) && !hold_d);
            d_oe_q      <= (state_d == S_EOI_WR);
            d_out_q     <= (state_d == S_EOI_WR) ? EOI_CMD : 8'h00;
            vec_valid_q <= (state_d == S_DELIVER);
            eoi_done_q  <= (state_d == S_EOI_REC) && (cnt_d == 4'd0);
            if ((state_q == S_ACK2) && (cnt_q == 4'd0)) begin
                vector_q <= d_in;
            end
        end
    end

    assign inta_n    = inta_n_q;
    assign cs_n      = strobe_n_q;
    assign wr_n      = strobe_n_q;
    assign rd_n      = 1'b1;
    assign a0        = 1'b0;
    assign d_oe      = d_oe_q;
    assign d_out     = d_out_q;
    assign vec_valid = vec_valid_q;
    assign vector    = vector_q;
    assign eoi_done  = eoi_done_q;

endmodule

// File: tb/tb_pic_host_if.sv
// Bench for pic_host_if with a behavioural interrupt-controller model (IRR/ISR, INTA, EOI).
`timescale 1ns/1ps
module tb_pic_host_if;

    localparam int P   = 4;
    localparam int G   = 2;
    localparam int LAT = 2 + 1 + 2*P + G;

    logic       clk = 1'b0;
    logic       rst;
    logic       intr, int_en, vec_ack, eoi_req;
    logic       vec_valid, eoi_done, inta_n, cs_n, wr_n, rd_n, a0, d_oe;
    logic [7:0] vector, d_out, d_in;

    int checks = 0;
    int errors = 0;

    // Controller model
    logic [7:0] irq_lines = 8'h00;
    logic [7:0] vec_base  = 8'h08;
    logic [7:0] isr       = 8'h00;
    logic [7:0] eoir      = 8'h00;
    logic [7:0] wr_lat    = 8'h00;
    logic [7:0] pending;
    logic       intr_force_en  = 1'b0;
    logic       intr_force_val = 1'b0;
    logic       in_pulse  = 1'b0;
    logic       wr_active = 1'b0;
    logic [2:0] cur_lvl   = 3'd0;
    int         pulse_n    = 0;
    int         eoi_writes = 0;

    always #5 clk = ~clk;

    pic_host_if dut (
        .clk       (clk),
        .rst       (rst),
        .intr      (intr),
        .int_en    (int_en),
        .vec_valid (vec_valid),
        .vector    (vector),
        .vec_ack   (vec_ack),
        .eoi_req   (eoi_req),
        .eoi_done  (eoi_done),
        .inta_n    (inta_n),
        .cs_n      (cs_n),
        .wr_n      (wr_n),
        .rd_n      (rd_n),
        .a0        (a0),
        .d_out     (d_out),
        .d_oe      (d_oe),
        .d_in      (d_in)
    );

    function automatic logic [2:0] lowest(input logic [7:0] v);
        logic [2:0] r = 3'd0;
        for (int i = 7; i >= 0; i--) if (v[i]) r = 3'(i);
        return r;
    endfunction

    assign pending = irq_lines & ~isr;
    assign intr = intr_force_en ? intr_force_val : ((pending != 8'h00) && (isr == 8'h00));
    assign d_in = (in_pulse && (pulse_n % 2 == 0)) ? vec_base + {5'd0, cur_lvl} : 8'hFF;

    always @(negedge clk or posedge rst) begin
        if (rst) begin
            pulse_n = 0; in_pulse = 1'b0; isr = 8'h00; eoir = 8'h00; wr_active = 1'b0; cur_lvl = 3'd0;
        end else begin
            if (!inta_n && !in_pulse) begin
                in_pulse = 1'b1;
                pulse_n++;
                if (pulse_n % 2 == 1) begin
                    cur_lvl = lowest(pending);
                    isr[cur_lvl] = 1'b1;
                end
            end else if (inta_n) begin
                in_pulse = 1'b0;
            end
            if (!cs_n && !wr_n) begin
                wr_active = 1'b1;
                wr_lat = d_out;
            end else if (wr_active) begin
                wr_active = 1'b0;
                eoir = wr_lat;
                eoi_writes++;
                if (wr_lat == 8'h20 && isr != 8'h00) isr[lowest(isr)] = 1'b0;
            end
        end
    end

    task automatic wait_vec(output int lat);
        lat = -1;
        for (int i = 1; i <= 60; i++) begin
            @(posedge clk); #1;
            if (vec_valid) begin lat = i; break; end
        end
        checks++;
        if (lat < 0) begin errors++; $display("FAIL wait_vec: vec_valid not seen in 60 cycles, required by %0d", LAT); end
    endtask

    task automatic ack_vec;
        @(negedge clk); vec_ack = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (vec_valid !== 1'b0) begin errors++; $display("FAIL ack_drop: vec_valid=%0b required 0", vec_valid); end
        @(negedge clk); vec_ack = 1'b0;
    endtask

    task automatic do_eoi(input logic [7:0] exp_isr);
        int n = -1;
        @(negedge clk); eoi_req = 1'b1;
        @(negedge clk); eoi_req = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (eoi_done) begin n = i; break; end
        end
        checks++;
        if (n < 0) begin errors++; $display("FAIL eoi_timeout: eoi_done not seen in 20 cycles, required"); end
        checks++;
        if (eoir !== 8'h20) begin errors++; $display("FAIL eoi_cmd: eoir=%h required 20", eoir); end
        checks++;
        if (isr !== exp_isr) begin errors++; $display("FAIL eoi_isr: isr=%h required %h", isr, exp_isr); end
        repeat (2) @(posedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        #1;
        checks++;
        if ({inta_n, cs_n, wr_n, rd_n} !== 4'b1111) begin errors++; $display("FAIL reset_strobes: %b required 1111", {inta_n, cs_n, wr_n, rd_n}); end
        checks++;
        if ({a0, d_oe, vec_valid, eoi_done} !== 4'b0000) begin errors++; $display("FAIL reset_flags: %b required 0000", {a0, d_oe, vec_valid, eoi_done}); end
        checks++;
        if ({vector, d_out} !== 16'h0000) begin errors++; $display("FAIL reset_data: vector=%h d_out=%h required 00 00", vector, d_out); end
        repeat (2) @(posedge clk);
        @(negedge clk); rst = 1'b0; int_en = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({inta_n, cs_n, vec_valid} !== 3'b110) begin errors++; $display("FAIL idle_after_reset: %b required 110", {inta_n, cs_n, vec_valid}); end
    endtask

    task automatic test_intack;
        logic tr [1:40];
        int   lat = -1, overlap = 0, run = 0, hrun = 0;
        logic seen_low = 1'b0;
        int   lows[$];
        int   gaps[$];
        for (int i = 1; i <= 40; i++) tr[i] = 1'b1;
        @(negedge clk); vec_base = 8'h08; irq_lines = 8'h08;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            tr[i] = inta_n;
            if (!inta_n && !cs_n) overlap++;
            if (vec_valid) begin lat = i; break; end
        end
        for (int i = 1; i <= lat; i++) begin
            if (!tr[i]) begin
                if (hrun > 0 && seen_low) gaps.push_back(hrun);
                hrun = 0; run++; seen_low = 1'b1;
            end else begin
                if (run > 0) lows.push_back(run);
                run = 0; hrun++;
            end
        end
        if (run > 0) lows.push_back(run);
        checks++;
        if (lat != LAT) begin errors++; $display("FAIL intack_latency: %0d cycles required %0d", lat, LAT); end
        checks++;
        if (vector !== 8'h0B) begin errors++; $display("FAIL intack_vector: %h required 0b", vector); end
        checks++;
        if (lows.size() != 2) begin errors++; $display("FAIL intack_pulses: %0d pulses required 2", lows.size()); end
        else begin
            checks++;
            if (lows[0] != P || lows[1] != P) begin errors++; $display("FAIL intack_width: %0d,%0d required %0d", lows[0], lows[1], P); end
        end
        checks++;
        if (gaps.size() != 1 || gaps[0] != G) begin errors++; $display("FAIL intack_gap: count=%0d required one gap of %0d", gaps.size(), G); end
        checks++;
        if (overlap != 0) begin errors++; $display("FAIL strobe_overlap: %0d cycles required 0", overlap); end
        irq_lines = 8'h00;
        checks++;
        if (isr !== 8'h08) begin errors++; $display("FAIL intack_isr: %h required 08", isr); end
        ack_vec();
    endtask

    task automatic test_eoi;
        logic       lo, oe, dn;
        logic [13:0] got, exp;
        int         w0 = eoi_writes;
        @(negedge clk); eoi_req = 1'b1;
        for (int k = 1; k <= P + G + 2; k++) begin
            @(posedge clk); #1;
            lo  = (k <= P);
            oe  = (k <= P + 1);
            dn  = (k == P + 1 + G);
            got = {cs_n, wr_n, a0, d_oe, d_out, eoi_done, inta_n};
            exp = {!lo, !lo, 1'b0, oe, oe ? 8'h20 : 8'h00, dn, 1'b1};
            checks++;
            if (got !== exp) begin errors++; $display("FAIL eoi_cycle%0d: {cs,wr,a0,oe,dout,done,inta}=%h required %h", k, got, exp); end
            @(negedge clk);
            if (k == 1) eoi_req = 1'b0;
        end
        checks++;
        if (eoir !== 8'h20) begin errors++; $display("FAIL eoi_eoir: %h required 20", eoir); end
        checks++;
        if (isr !== 8'h00) begin errors++; $display("FAIL eoi_isr_clear: %h required 00", isr); end
        checks++;
        if (eoi_writes != w0 + 1) begin errors++; $display("FAIL eoi_count: %0d writes required 1", eoi_writes - w0); end
    endtask

    task automatic test_int_en;
        int         lows = 0, lat;
        logic [2:0] lvl = 3'($urandom_range(0, 7));
        @(negedge clk);
        int_en = 1'b0; vec_base = 8'($urandom_range(0, 31)) << 3; irq_lines = 8'(1 << lvl);
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #1;
            if (!inta_n) lows++;
        end
        checks++;
        if (lows != 0) begin errors++; $display("FAIL int_en_masked: %0d low cycles required 0", lows); end
        @(negedge clk); int_en = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (inta_n !== 1'b0) begin errors++; $display("FAIL int_en_start: inta_n=%b required 0", inta_n); end
        wait_vec(lat);
        checks++;
        if (vector !== vec_base + 8'(lvl)) begin errors++; $display("FAIL int_en_vector: %h required %h", vector, vec_base + 8'(lvl)); end
        irq_lines = 8'h00;
        ack_vec();
        do_eoi(8'h00);
    endtask

    task automatic test_coincide;
        int n = -1, lat;
        @(negedge clk); vec_base = 8'h08; irq_lines = 8'h01;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk); eoi_req = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({cs_n, inta_n} !== 2'b01) begin errors++; $display("FAIL coincide_prio: {cs_n,inta_n}=%b required 01", {cs_n, inta_n}); end
        @(negedge clk); eoi_req = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (eoi_done) begin n = i; break; end
        end
        checks++;
        if (n < 0) begin errors++; $display("FAIL coincide_eoi: eoi_done not seen, required"); end
        n = -1;
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk); #1;
            if (!inta_n) begin n = i; break; end
        end
        checks++;
        if (n != 2) begin errors++; $display("FAIL coincide_follow: inta after %0d cycles required 2", n); end
        wait_vec(lat);
        checks++;
        if (vector !== 8'h08) begin errors++; $display("FAIL coincide_vector: %h required 08", vector); end
        checks++;
        if (eoir !== 8'h20) begin errors++; $display("FAIL coincide_eoir: %h required 20", eoir); end
        irq_lines = 8'h00;
        ack_vec();
        do_eoi(8'h00);
    endtask

    task automatic test_deliver_hold;
        int         lat;
        logic [7:0] v0;
        logic [2:0] lvl = 3'($urandom_range(0, 7));
        @(negedge clk); vec_base = 8'h40; irq_lines = 8'(1 << lvl);
        wait_vec(lat);
        v0 = vector;
        irq_lines = 8'h00;
        checks++;
        if (v0 !== 8'h40 + 8'(lvl)) begin errors++; $display("FAIL hold_vector: %h required %h", v0, 8'h40 + 8'(lvl)); end
        intr_force_en = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); intr_force_val = 1'($urandom);
            @(posedge clk); #1;
            checks++;
            if ({vec_valid, inta_n, vector} !== {2'b11, v0}) begin
                errors++; $display("FAIL hold_cycle%0d: valid=%b inta_n=%b vector=%h required 1 1 %h", i, vec_valid, inta_n, vector, v0);
            end
        end
        @(negedge clk); intr_force_en = 1'b0;
        repeat (3) @(posedge clk);
        ack_vec();
        do_eoi(8'h00);
    endtask

    task automatic test_random;
        for (int it = 0; it < 6; it++) begin
            int         lat;
            int         dly = $urandom_range(0, 4);
            logic [2:0] lvl = 3'($urandom_range(0, 7));
            logic [7:0] expv;
            @(negedge clk);
            vec_base = 8'($urandom_range(0, 31)) << 3;
            irq_lines = 8'(1 << lvl);
            expv = vec_base + 8'(lvl);
            wait_vec(lat);
            irq_lines = 8'h00;
            checks++;
            if (lat != LAT) begin errors++; $display("FAIL rand%0d_latency: %0d required %0d", it, lat, LAT); end
            checks++;
            if (vector !== expv) begin errors++; $display("FAIL rand%0d_vector: %h required %h", it, vector, expv); end
            repeat (dly) @(posedge clk);
            #1;
            checks++;
            if (vec_valid !== 1'b1) begin errors++; $display("FAIL rand%0d_valid_hold: %b required 1", it, vec_valid); end
            ack_vec();
            do_eoi(8'h00);
        end
    endtask

    task automatic test_reset_mid_ack2;
        @(negedge clk); vec_base = 8'h08; irq_lines = 8'h04;
        repeat (10) @(posedge clk);
        #1;
        checks++;
        if (inta_n !== 1'b0) begin errors++; $display("FAIL mid_ack2_reach: inta_n=%b required 0", inta_n); end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({inta_n, cs_n, vec_valid} !== 3'b110) begin errors++; $display("FAIL mid_ack2_reset: {inta_n,cs_n,valid}=%b required 110", {inta_n, cs_n, vec_valid}); end
        irq_lines = 8'h00;
        @(negedge clk); rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checks++;
            if ({inta_n, cs_n, vec_valid} !== 3'b110) begin errors++; $display("FAIL post_reset%0d: %b required 110", i, {inta_n, cs_n, vec_valid}); end
        end
    endtask

    initial begin
        rst = 1'b1; int_en = 1'b0; vec_ack = 1'b0; eoi_req = 1'b0;
        test_reset();
        test_intack();
        test_eoi();
        test_int_en();
        test_coincide();
        test_deliver_hold();
        test_random();
        test_reset_mid_ack2();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
